// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } boot_state_t;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_byte_serializer.sv
// Splits a 32-bit instruction word into bytes, least-significant byte first.
// The current byte is taken straight from the low bits of a shift register so
// the byte output is a flop output; the register drains to zero after the
// final byte.
module imem_byte_serializer
    import imem_boot_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORD_W-1:0]     word_in,
    input  logic                  advance,
    output logic [BYTE_W-1:0]     byte_o,
    output logic [BYTE_IDX_W-1:0] byte_idx,
    output logic                  last_byte
);

    logic [WORD_W-1:0]     shreg_q, shreg_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    // Next-state: load a fresh word, or shift one byte out per advance
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = word_in;
            idx_d   = '0;
        end else if (advance) begin
            shreg_d = {{BYTE_W{1'b0}}, shreg_q[WORD_W-1:BYTE_W]};
            idx_d   = idx_q + BYTE_IDX_W'(1);
        end
    end

    // Shift register and byte index storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign byte_o    = shreg_q[BYTE_W-1:0];
    assign byte_idx  = idx_q;
    assign last_byte = (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader for the core's byte-wide instruction memory. Takes 32-bit words
// from a valid/ready stream, writes each as four little-endian byte writes,
// and holds the core until the load completes.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned MAX_WORDS = 128,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              core_hold,
    output logic              done,
    output logic [CNT_W-1:0]  word_count,
    output logic              err
);

    boot_state_t           state_q, state_d;
    logic                  im_we_q, im_we_d;
    logic [ADDR_W-1:0]     im_addr_q, im_addr_d;
    logic                  core_hold_q, core_hold_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      word_count_q, word_count_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;

    logic                  ser_load;
    logic                  ser_advance;
    logic [BYTE_W-1:0]     ser_byte;
    logic [BYTE_IDX_W-1:0] ser_idx;
    logic                  ser_last;

    logic [ADDR_W-1:0]     word_base;
    logic [CNT_W-1:0]      cnt_next;

    imem_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word_in   (in_data),
        .advance   (ser_advance),
        .byte_o    (ser_byte),
        .byte_idx  (ser_idx),
        .last_byte (ser_last)
    );

    // Byte address of byte 0 of the word currently being written; word_count
    // only changes on the edge that ends a word, so it is stable across WRITE.
    assign word_base = ADDR_W'(BASE_ADDR) + (ADDR_W'(word_count_q) << BYTE_IDX_W);
    assign cnt_next  = word_count_q + CNT_W'(1);

    // Next-state and next-output decode for the load sequence
    always_comb begin
        state_d      = state_q;
        im_we_d      = im_we_q;
        im_addr_d    = im_addr_q;
        core_hold_d  = core_hold_q;
        done_d       = done_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        last_d       = last_q;
        ser_load     = 1'b0;
        ser_advance  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = ACCEPT;
                    word_count_d = '0;
                    err_d        = 1'b0;
                    done_d       = 1'b0;
                    core_hold_d  = 1'b1;
                end
            end
            ACCEPT: begin
                // in_ready is high throughout ACCEPT, so in_valid alone completes the handshake
                if (in_valid) begin
                    state_d   = WRITE;
                    ser_load  = 1'b1;
                    last_d    = in_last;
                    im_we_d   = 1'b1;
                    im_addr_d = word_base;
                end
            end
            WRITE: begin
                ser_advance = 1'b1;
                if (ser_last) begin
                    im_we_d      = 1'b0;
                    word_count_d = cnt_next;
                    if (last_q || (cnt_next == CNT_W'(MAX_WORDS))) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                        err_d       = err_q | ~last_q;
                    end else begin
                        state_d = ACCEPT;
                    end
                end else begin
                    im_addr_d = word_base + ADDR_W'(ser_idx) + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            core_hold_q  <= core_hold_d;
            done_q       <= done_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            last_q       <= last_d;
        end
    end

    assign in_ready   = (state_q == ACCEPT);
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = ser_byte;
    assign core_hold  = core_hold_q;
    assign done       = done_q;
    assign word_count = word_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed-vector bench for imem_boot_loader (MAX_WORDS overridden to 4).
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        im_we;
    logic [8:0]  im_addr;
    logic [7:0]  im_wdata;
    logic        core_hold;
    logic        done;
    logic [7:0]  word_count;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t wr_q[$];
    wr_t mon_w;
    int  cyc = 0;
    int  overlap = 0;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .ADDR_W    (9),
        .MAX_WORDS (4),
        .BASE_ADDR (0),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .word_count (word_count),
        .err        (err)
    );

    // Record every byte write seen at a clock edge, with its cycle number
    always @(posedge clk) begin
        if (!rst && im_we) begin
            mon_w.addr = im_addr;
            mon_w.data = im_wdata;
            mon_w.cyc  = cyc;
            wr_q.push_back(mon_w);
            if (in_ready) overlap++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        tick(); tick();
        n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL reset_core_hold: got %b want 1", core_hold); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL reset_im_we: got %b want 0", im_we); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (im_addr !== 9'd0) begin n_bad++; $display("FAIL reset_im_addr: got %0d want 0", im_addr); end
        n_cmp++; if (im_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_im_wdata: got %h want 00", im_wdata); end
        rst = 1'b0;
        tick();
        wr_q.delete();
        // Valid data while idle must not be taken
        in_valid = 1'b1; in_data = 32'h12345678;
        repeat (3) tick();
        n_cmp++; if (wr_q.size() !== 0) begin n_bad++; $display("FAIL idle_no_write: got %0d writes want 0", wr_q.size()); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        logic [7:0]  eb;
        int t;
        w = 32'hDEADBEEF;
        wr_q.delete();
        start = 1'b1; in_valid = 1'b1; in_data = w; in_last = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", in_ready); end
        n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL single_hold_loading: got %b want 1", core_hold); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if (im_we !== 1'b1) begin n_bad++; $display("FAIL single_first_we: got %b want 1", im_we); end
        n_cmp++; if (im_wdata !== 8'hEF) begin n_bad++; $display("FAIL single_first_byte: got %h want ef", im_wdata); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_in_write: got %b want 0", in_ready); end
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        n_cmp++; if (t !== 4) begin n_bad++; $display("FAIL single_done_latency: got %0d cycles want 4", t); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", done); end
        n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL single_release: got %b want 0", core_hold); end
        n_cmp++; if (word_count !== 8'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", word_count); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
        n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL single_we_after: got %b want 0", im_we); end
        n_cmp++; if (wr_q.size() !== 4) begin n_bad++; $display("FAIL single_nwrites: got %0d want 4", wr_q.size()); end
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            eb = 8'(w >> (8 * i));
            n_cmp++; if (wr_q[i].addr !== 9'(i)) begin n_bad++; $display("FAIL single_addr[%0d]: got %0d want %0d", i, wr_q[i].addr, i); end
            n_cmp++; if (wr_q[i].data !== eb) begin n_bad++; $display("FAIL single_data[%0d]: got %h want %h", i, wr_q[i].data, eb); end
            n_cmp++; if (wr_q[i].cyc !== wr_q[0].cyc + i) begin n_bad++; $display("FAIL single_consec[%0d]: got cycle %0d want %0d", i, wr_q[i].cyc, wr_q[0].cyc + i); end
        end
    endtask

    task automatic test_three_words();
        logic [31:0] wv [3];
        logic [31:0] w;
        logic [7:0]  eb;
        int t;
        wv[0] = 32'h00500093; wv[1] = 32'h00100113; wv[2] = 32'h002081B3;
        wr_q.delete(); overlap = 0;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = wv[i]; in_last = (i == 2);
            t = 0;
            while (!in_ready && t < 20) begin tick(); t++; end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL three_handshake[%0d]: got in_ready %b want 1", i, in_ready); end
            tick();
        end
        in_data = 32'hFFFFFFFF; in_last = 1'b0;
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL three_done: got %b want 1", done); end
        n_cmp++; if (word_count !== 8'd3) begin n_bad++; $display("FAIL three_count: got %0d want 3", word_count); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL three_err: got %b want 0", err); end
        repeat (4) tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL three_no_accept_done: got %b want 0", in_ready); end
        in_valid = 1'b0;
        n_cmp++; if (wr_q.size() !== 12) begin n_bad++; $display("FAIL three_nwrites: got %0d want 12", wr_q.size()); end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL three_ready_during_write: got %0d want 0", overlap); end
        for (int i = 0; i < 12 && i < wr_q.size(); i++) begin
            w  = wv[i / 4];
            eb = 8'(w >> (8 * (i % 4)));
            n_cmp++; if (wr_q[i].addr !== 9'(i)) begin n_bad++; $display("FAIL three_addr[%0d]: got %0d want %0d", i, wr_q[i].addr, i); end
            n_cmp++; if (wr_q[i].data !== eb) begin n_bad++; $display("FAIL three_data[%0d]: got %h want %h", i, wr_q[i].data, eb); end
        end
        if (wr_q.size() >= 12) begin
            n_cmp++; if (wr_q[4].cyc - wr_q[0].cyc !== 5) begin n_bad++; $display("FAIL three_rate_w1: got %0d want 5", wr_q[4].cyc - wr_q[0].cyc); end
            n_cmp++; if (wr_q[8].cyc - wr_q[4].cyc !== 5) begin n_bad++; $display("FAIL three_rate_w2: got %0d want 5", wr_q[8].cyc - wr_q[4].cyc); end
        end
    endtask

    task automatic test_overflow();
        int t;
        wr_q.delete();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'h03020100 + 32'(k) * 32'h04040404;
            t = 0;
            while (!in_ready && t < 20) begin tick(); t++; end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_handshake[%0d]: got %b want 1", k, in_ready); end
            tick();
        end
        in_data = 32'h13121110;
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ovf_done: got %b want 1", done); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", err); end
        n_cmp++; if (word_count !== 8'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", word_count); end
        n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL ovf_release: got %b want 0", core_hold); end
        repeat (6) tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_fifth_refused: got %b want 0", in_ready); end
        in_valid = 1'b0;
        n_cmp++; if (wr_q.size() !== 16) begin n_bad++; $display("FAIL ovf_nwrites: got %0d want 16", wr_q.size()); end
        for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
            n_cmp++; if (wr_q[i].addr !== 9'(i) || wr_q[i].data !== 8'(i)) begin
                n_bad++; $display("FAIL ovf_write[%0d]: got %0d/%h want %0d/%h", i, wr_q[i].addr, wr_q[i].data, i, 8'(i));
            end
        end
    endtask

    task automatic test_start_control();
        int t;
        wr_q.delete();
        // Entered from DONE with err set by the overflow load
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL restart_err_clear: got %b want 0", err); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done_clear: got %b want 0", done); end
        n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL restart_hold: got %b want 1", core_hold); end
        n_cmp++; if (word_count !== 8'd0) begin n_bad++; $display("FAIL restart_count: got %0d want 0", word_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; in_data = 32'h44332211; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (im_we !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL start_in_write: got we=%b rdy=%b want we=1 rdy=0", im_we, in_ready); end
        t = 0;
        while (!in_ready && t < 20) begin tick(); t++; end
        n_cmp++; if (word_count !== 8'd1) begin n_bad++; $display("FAIL start_in_write_count: got %0d want 1", word_count); end
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (word_count !== 8'd1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL start_in_accept: got cnt=%0d rdy=%b want cnt=1 rdy=1", word_count, in_ready); end
        in_valid = 1'b1; in_data = 32'h88776655; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        n_cmp++; if (done !== 1'b1 || word_count !== 8'd2 || err !== 1'b0) begin
            n_bad++; $display("FAIL restart_end: got done=%b cnt=%0d err=%b want done=1 cnt=2 err=0", done, word_count, err);
        end
        n_cmp++; if (wr_q.size() !== 8) begin n_bad++; $display("FAIL restart_nwrites: got %0d want 8", wr_q.size()); end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_cmp++; if (wr_q[i].addr !== 9'(i) || wr_q[i].data !== 8'(8'h11 * (i + 1))) begin
                n_bad++; $display("FAIL restart_write[%0d]: got %0d/%h want %0d/%h", i, wr_q[i].addr, wr_q[i].data, i, 8'(8'h11 * (i + 1)));
            end
        end
    endtask

    task automatic test_max_with_last();
        int t;
        wr_q.delete();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'hA0000000 | 32'(k); in_last = (k == 3);
            t = 0;
            while (!in_ready && t < 20) begin tick(); t++; end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL maxlast_handshake[%0d]: got %b want 1", k, in_ready); end
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        n_cmp++; if (done !== 1'b1 || err !== 1'b0 || word_count !== 8'd4) begin
            n_bad++; $display("FAIL maxlast_end: got done=%b err=%b cnt=%0d want done=1 err=0 cnt=4", done, err, word_count);
        end
        n_cmp++; if (wr_q.size() !== 16) begin n_bad++; $display("FAIL maxlast_nwrites: got %0d want 16", wr_q.size()); end
    endtask

    task automatic test_reset_mid_load();
        int t;
        logic [31:0] w;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'hA3A2A1A0; in_last = 1'b0;
        tick();
        in_data = 32'hB3B2B1B0;
        t = 0;
        while (!in_ready && t < 20) begin tick(); t++; end
        tick();
        in_valid = 1'b0;
        t = 0;
        while (!(im_we && im_addr == 9'd6) && t < 20) begin tick(); t++; end
        n_cmp++; if (im_we !== 1'b1 || im_addr !== 9'd6 || im_wdata !== 8'hB2) begin
            n_bad++; $display("FAIL midrst_reach_byte2: got we=%b addr=%0d data=%h want we=1 addr=6 data=b2", im_we, im_addr, im_wdata);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we: got %b want 0", im_we); end
        n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL midrst_hold: got %b want 1", core_hold); end
        n_cmp++; if (word_count !== 8'd0 || im_addr !== 9'd0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL midrst_state: got cnt=%0d addr=%0d rdy=%b want 0/0/0", word_count, im_addr, in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        wr_q.delete();
        w = 32'hCAFEF00D;
        start = 1'b1; in_valid = 1'b1; in_data = w; in_last = 1'b1;
        tick(); start = 1'b0;
        tick(); in_valid = 1'b0; in_last = 1'b0;
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        n_cmp++; if (done !== 1'b1 || word_count !== 8'd1) begin n_bad++; $display("FAIL midrst_reload: got done=%b cnt=%0d want 1/1", done, word_count); end
        n_cmp++; if (wr_q.size() !== 4) begin n_bad++; $display("FAIL midrst_nwrites: got %0d want 4", wr_q.size()); end
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            n_cmp++; if (wr_q[i].addr !== 9'(i) || wr_q[i].data !== 8'(w >> (8 * i))) begin
                n_bad++; $display("FAIL midrst_write[%0d]: got %0d/%h want %0d/%h", i, wr_q[i].addr, wr_q[i].data, i, 8'(w >> (8 * i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_three_words();
        test_overflow();
        test_start_control();
        test_max_with_last();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
